banked_mem_model: RTL and testbench

Four-bank, word-interleaved main-memory block that sits directly downstream of the data cache controller. It accepts one read or write request per cycle and returns read data a fixed two cycles after acceptance. It reports per-bank busy status and stalls requests that hit a busy bank. The controller's burst evict and burst fill sequences issue one access to each bank in four consecutive cycles, and this block serves them back-to-back without stalling.

---
 rtl/banked_mem_model.sv | 91 +++++++++
 tb/tb_banked_mem_model.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_model.sv
// Four-bank word-interleaved memory: one request per cycle, fixed two-cycle
// read return, per-bank occupancy counters that stall conflicting requests.
module banked_mem_model #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int BANK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int         WORDS    = 2 ** (ADDR_W - 1);
  localparam logic [3:0] OCC_LOAD = 4'(BANK_CYCLES - 1);

  logic [3:0]        bank_cnt_reg [4];
  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] s1_data_reg;
  logic              s1_valid_reg;
  logic [DATA_W-1:0] s2_data_reg;

  logic              present;
  logic              illegal;
  logic              bank_busy;
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;
  logic [1:0]        bank_sel;
  logic [ADDR_W-2:0] word_idx;

  always_comb begin
    bank_sel  = addr[2:1];
    word_idx  = addr[ADDR_W-1:1];
    present   = rd | wr;
    illegal   = (rd & wr) | (present & addr[0]);
    bank_busy = busy[bank_sel];
    // Requests seen while reset is asserted are dropped, not queued.
    accept    = present & ~illegal & ~bank_busy & rst;
    rd_accept = accept & rd;
    wr_accept = accept & wr;
    stall     = present & ~illegal & bank_busy;
    err       = illegal;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      assign busy[gi] = (bank_cnt_reg[gi] != 4'd0);

      always_ff @(posedge clk) begin
        if (!rst) begin
          bank_cnt_reg[gi] <= 4'd0;
        end else if (accept && (bank_sel == 2'(gi))) begin
          bank_cnt_reg[gi] <= OCC_LOAD;
        end else if (bank_cnt_reg[gi] != 4'd0) begin
          bank_cnt_reg[gi] <= bank_cnt_reg[gi] - 4'd1;
        end
      end
    end
  endgenerate

  // Storage and its output register stay reset-free so they map onto block RAM;
  // the stage-1 valid flag masks the RAM output register instead.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word_idx] <= data_in;
    end
    if (rd_accept) begin
      s1_data_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_accept;
      s2_data_reg  <= s1_valid_reg ? s1_data_reg : '0;
    end
  end

  assign data_out = s2_data_reg;

endmodule

// File: tb/tb_banked_mem_model.sv
// Bench for banked_mem_model: a BANK_CYCLES=4 and a BANK_CYCLES=1 instance share
// stimulus; a cycle-count reference model plus a directed vector table check them.
module tb_banked_mem_model;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] data_in = 16'h0;

  logic [15:0] data_out0, data_out1;
  logic        stall0, stall1, err0, err1;
  logic [3:0]  busy0, busy1;

  banked_mem_model #(.DATA_W(16), .ADDR_W(16), .BANK_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out0), .stall(stall0), .busy(busy0), .err(err0)
  );

  banked_mem_model #(.DATA_W(16), .ADDR_W(16), .BANK_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out1), .stall(stall1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;

  // Reference model: a bank is free from cycle free_at onward; a read accepted
  // in cycle c is expected on data_out in cycle c+2.
  int          bc [2] = '{4, 1};
  int          free_at [2][4];
  int          ret_cyc [2][8];
  logic [15:0] ret_val [2][8];
  logic [15:0] mem_m [2][32768];

  typedef struct {
    logic        rstn;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        st;
    logic        er;
    logic [3:0]  bz;
    logic [15:0] d0;
    logic [15:0] d1;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  function automatic logic [3:0] m_busy(input int d);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (cyc < free_at[d][i]);
    return b;
  endfunction

  task automatic model_check();
    logic        present, ill, e_stall;
    logic [3:0]  mb;
    logic [15:0] ed;
    present = rd | wr;
    ill = (rd & wr) | (present & addr[0]);
    for (int d = 0; d < 2; d++) begin
      mb = m_busy(d);
      e_stall = present & ~ill & mb[addr[2:1]];
      ed = (ret_cyc[d][cyc % 8] == cyc) ? ret_val[d][cyc % 8] : 16'h0;
      if (d == 0) begin
        chk("m0_stall", 32'(stall0), 32'(e_stall));
        chk("m0_err", 32'(err0), 32'(ill));
        chk("m0_busy", 32'(busy0), 32'(mb));
        chk("m0_data_out", 32'(data_out0), 32'(ed));
      end else begin
        chk("m1_stall", 32'(stall1), 32'(e_stall));
        chk("m1_err", 32'(err1), 32'(ill));
        chk("m1_busy", 32'(busy1), 32'(mb));
        chk("m1_data_out", 32'(data_out1), 32'(ed));
      end
    end
  endtask

  task automatic model_update();
    logic       present, ill;
    logic [3:0] mb;
    int         b;
    present = rd | wr;
    ill = (rd & wr) | (present & addr[0]);
    b = int'(addr[2:1]);
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        for (int i = 0; i < 4; i++) free_at[d][i] = 0;
        for (int s = 0; s < 8; s++) if (ret_cyc[d][s] > cyc) ret_cyc[d][s] = -1;
      end else begin
        mb = m_busy(d);
        if (present && !ill && !mb[b]) begin
          if (wr) mem_m[d][addr[15:1]] = data_in;
          else begin
            ret_cyc[d][(cyc + 2) % 8] = cyc + 2;
            ret_val[d][(cyc + 2) % 8] = mem_m[d][addr[15:1]];
          end
          free_at[d][b] = cyc + bc[d];
        end
      end
    end
  endtask

  task automatic apply(input logic r, input logic rdv, input logic wrv,
                       input logic [15:0] a, input logic [15:0] dv);
    @(negedge clk);
    rst = r; rd = rdv; wr = wrv; addr = a; data_in = dv;
    #1;
    if (chk_en) model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    cyc++;
  endtask

  task automatic add(input logic rn, input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] dv, input logic st, input logic er,
                     input logic [3:0] bz, input logic [15:0] d0, input logic [15:0] d1);
    vec_t v;
    v.rstn = rn; v.rd = r; v.wr = w; v.addr = a; v.din = dv;
    v.st = st; v.er = er; v.bz = bz; v.d0 = d0; v.d1 = d1;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic [3:0] bz, input logic [15:0] d0, input logic [15:0] d1);
    add(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, bz, d0, d1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) free_at[d][i] = 0;
      for (int s = 0; s < 8; s++) begin ret_cyc[d][s] = -1; ret_val[d][s] = 16'h0; end
    end

    // Write BEEF to 0x0008, read it back five cycles later.
    add(1, 0, 1, 16'h0008, 16'hBEEF, 0, 0, 4'b0000, 16'h0, 16'h0);
    idle(4'b0001, 0, 0); idle(4'b0001, 0, 0); idle(4'b0001, 0, 0); idle(4'b0000, 0, 0);
    add(1, 1, 0, 16'h0008, 16'h0, 0, 0, 4'b0000, 16'h0, 16'h0);
    idle(4'b0001, 0, 0); idle(4'b0001, 16'hBEEF, 16'hBEEF); idle(4'b0001, 0, 0);
    idle(4'b0000, 0, 0);
    // Burst read across the four banks; bank 0 frees one cycle after the last accept.
    add(1, 1, 0, 16'h0100, 16'h0, 0, 0, 4'b0000, 16'h0, 16'h0);
    add(1, 1, 0, 16'h0102, 16'h0, 0, 0, 4'b0001, 16'h0, 16'h0);
    add(1, 1, 0, 16'h0104, 16'h0, 0, 0, 4'b0011, 16'h1, 16'h1);
    add(1, 1, 0, 16'h0106, 16'h0, 0, 0, 4'b0111, 16'h2, 16'h2);
    idle(4'b1110, 16'h3, 16'h3); idle(4'b1100, 16'h4, 16'h4); idle(4'b1000, 0, 0);
    idle(4'b0000, 0, 0);
    // Bank 0 conflict: second read held through three stalled cycles.
    add(1, 1, 0, 16'h0000, 16'h0, 0, 0, 4'b0000, 16'h0, 16'h0);
    add(1, 1, 0, 16'h0008, 16'h0, 1, 0, 4'b0001, 16'h0, 16'h0);
    add(1, 1, 0, 16'h0008, 16'h0, 1, 0, 4'b0001, 16'h5A00, 16'h5A00);
    add(1, 1, 0, 16'h0008, 16'h0, 1, 0, 4'b0001, 16'h0, 16'hBEEF);
    add(1, 1, 0, 16'h0008, 16'h0, 0, 0, 4'b0000, 16'h0, 16'hBEEF);
    idle(4'b0001, 0, 16'hBEEF); idle(4'b0001, 16'hBEEF, 16'hBEEF); idle(4'b0001, 0, 0);
    idle(4'b0000, 0, 0);
    // Illegal requests leave storage at 0x0010 untouched.
    add(1, 1, 1, 16'h0010, 16'hDEAD, 0, 1, 4'b0000, 16'h0, 16'h0);
    add(1, 1, 0, 16'h0011, 16'h0, 0, 1, 4'b0000, 16'h0, 16'h0);
    add(1, 0, 1, 16'h0011, 16'hDEAD, 0, 1, 4'b0000, 16'h0, 16'h0);
    add(1, 1, 0, 16'h0010, 16'h0, 0, 0, 4'b0000, 16'h0, 16'h0);
    idle(4'b0001, 0, 0); idle(4'b0001, 16'h5A08, 16'h5A08); idle(4'b0001, 0, 0);
    idle(4'b0000, 0, 0);
    // Reset discards a pending return and ignores a same-cycle write.
    add(1, 1, 0, 16'h0102, 16'h0, 0, 0, 4'b0000, 16'h0, 16'h0);
    add(0, 0, 0, 16'h0, 16'h0, 0, 0, 4'b0010, 16'h0, 16'h0);
    idle(4'b0000, 0, 0); idle(4'b0000, 0, 0);
    add(0, 0, 1, 16'h0104, 16'hFFFF, 0, 0, 4'b0000, 16'h0, 16'h0);
    idle(4'b0000, 0, 0);
    add(1, 1, 0, 16'h0104, 16'h0, 0, 0, 4'b0000, 16'h0, 16'h0);
    idle(4'b0100, 0, 0); idle(4'b0100, 16'h3, 16'h3); idle(4'b0100, 0, 0);
    idle(4'b0000, 0, 0);

    apply(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    advance();
    chk_en = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("reset_busy0", 32'(busy0), 32'h0);
    chk("reset_data_out0", 32'(data_out0), 32'h0);
    chk("reset_stall0", 32'(stall0), 32'h0);
    chk("reset_err0", 32'(err0), 32'h0);
    advance();

    // Preload: consecutive words rotate through the banks, so no stalls.
    for (int i = 0; i < 32; i++) begin
      apply(1'b1, 1'b0, 1'b1, 16'(i * 2), 16'h5A00 + 16'(i));
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b1, 16'h0100 + 16'(i * 2), 16'(i + 1));
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      advance();
    end

    foreach (tbl[i]) begin
      apply(tbl[i].rstn, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      chk($sformatf("v%0d_stall0", i), 32'(stall0), 32'(tbl[i].st));
      chk($sformatf("v%0d_err0", i), 32'(err0), 32'(tbl[i].er));
      chk($sformatf("v%0d_busy0", i), 32'(busy0), 32'(tbl[i].bz));
      chk($sformatf("v%0d_data_out0", i), 32'(data_out0), 32'(tbl[i].d0));
      chk($sformatf("v%0d_data_out1", i), 32'(data_out1), 32'(tbl[i].d1));
      chk($sformatf("v%0d_stall1", i), 32'(stall1), 32'h0);
      chk($sformatf("v%0d_busy1", i), 32'(busy1), 32'h0);
      advance();
    end

    for (int i = 0; i < 400; i++) begin
      logic        r, rv, wv;
      logic [15:0] a;
      int          op;
      r = ($urandom_range(0, 49) != 0);
      op = $urandom_range(0, 7);
      rv = (op <= 2) || (op == 6);
      wv = (op >= 3 && op <= 6);
      a = 16'({$urandom_range(0, 31), 1'b0});
      if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
      apply(r, rv, wv, a, 16'($urandom));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
